// File: rtl/rrobin_pkg.sv
// rrobin_pkg
// Shared definitions for the N-channel round-robin arbiter:
//   rr_limit    - worst-case wait L = (N-1)*HOLD + 1 a fair arbiter can impose
//   ptr_width   - bits for the rotating pointer / owner index
//   hold_width  - bits for the consecutive-hold counter
//   wcnt_width  - bits for a wait counter that saturates at L+1
//   grant_state_t - idle / granting state of the grant FSM
package rrobin_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } grant_state_t;

  function automatic int rr_limit(input int n, input int hold);
    return (n - 1) * hold + 1;
  endfunction

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int hold_width(input int hold);
    return $clog2(hold + 1);
  endfunction

  // Counter must be able to hold L+1, hence L+2 distinct values.
  function automatic int wcnt_width(input int n, input int hold);
    return $clog2(rr_limit(n, hold) + 2);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin winner search.
// Ports:
//   req    in  N   - latched request vector
//   ptr    in  PW  - channel with highest priority this cycle
//   winner out PW  - first requesting channel scanning ptr, ptr+1, ... mod N
//   any    out 1   - at least one channel requests
module rr_pick
  import rrobin_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any
);

  localparam int SW = PW + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  sum;

  // Doubling the request vector turns the circular scan into a plain shift:
  // bit j of rot is channel (ptr+j) mod N. Scanning downwards lets the lowest
  // set offset (closest to ptr) overwrite any later one.
  always_comb begin
    dbl    = {req, req};
    rot    = N'(dbl >> ptr);
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr} + SW'(j);
        if (sum >= SW'(N)) begin
          sum = sum - SW'(N);
        end
        winner = sum[PW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rrobin_n.sv
// rrobin_n
// N-channel round-robin arbiter with a hold limit and a starvation monitor.
// Raw requests are latched, then a registered one-hot grant is issued from the
// latched requests, so a request appears on ack two cycles after ir.
// Ports:
//   clock  in  1         - rising-edge clock
//   reset  in  1         - asynchronous active-high reset
//   ir     in  N         - raw requests
//   ack    out N         - registered grant, one-hot or zero
//   owner  out $clog2(N) - index of granted channel (valid when ack != 0)
//   starve out 1         - sticky: some channel waited longer than L cycles
module rrobin_n
  import rrobin_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         ir,
  output logic [N-1:0]         ack,
  output logic [$clog2(N)-1:0] owner,
  output logic                 starve
);

  localparam int PW = ptr_width(N);
  localparam int HW = hold_width(HOLD);
  localparam int L  = rr_limit(N, HOLD);
  localparam int WW = wcnt_width(N, HOLD);

  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);
  localparam logic [WW-1:0] WAIT_MAX = WW'(L + 1);
  localparam logic [N-1:0]  ONE      = N'(1);
  localparam logic [PW-1:0] LAST     = PW'(N - 1);

  grant_state_t  state_r, state_n;
  logic [N-1:0]  req_r;
  logic [N-1:0]  ack_r, ack_n;
  logic [PW-1:0] owner_r, owner_n;
  logic [PW-1:0] ptr_r, ptr_n;
  logic [HW-1:0] hold_r, hold_n;
  logic [PW-1:0] pick_winner;
  logic          pick_any;
  logic          owner_req;
  logic          others_req;

  logic [WW-1:0] wcnt [N];
  logic          wait_hit;
  logic          starve_r;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req    (req_r),
    .ptr    (ptr_r),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign owner_req  = |(req_r & ack_r);
  assign others_req = |(req_r & ~ack_r);

  // State register: request latch plus all grant state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      req_r   <= '0;
      ack_r   <= '0;
      owner_r <= '0;
      ptr_r   <= '0;
      hold_r  <= '0;
    end else begin
      state_r <= state_n;
      req_r   <= ir;
      ack_r   <= ack_n;
      owner_r <= owner_n;
      ptr_r   <= ptr_n;
      hold_r  <= hold_n;
    end
  end

  // Next-state: an owner keeps the grant while it requests and either nobody
  // else is waiting or it has not used up its HOLD cycles. Anything else
  // (owner dropped, hold exhausted, or idle) re-arbitrates from ptr on this
  // same edge. The pointer moves past the winner only on a fresh grant.
  always_comb begin
    state_n = state_r;
    ack_n   = ack_r;
    owner_n = owner_r;
    ptr_n   = ptr_r;
    hold_n  = hold_r;
    if (!pick_any) begin
      state_n = ST_IDLE;
      ack_n   = '0;
      hold_n  = '0;
    end else if (state_r == ST_GRANT && owner_req &&
                 (!others_req || hold_r < HOLD_MAX)) begin
      if (hold_r < HOLD_MAX) begin
        hold_n = hold_r + 1'b1;
      end
    end else begin
      state_n = ST_GRANT;
      ack_n   = ONE << pick_winner;
      owner_n = pick_winner;
      ptr_n   = (pick_winner == LAST) ? '0 : pick_winner + 1'b1;
      hold_n  = HW'(1);
    end
  end

  // Outputs are straight copies of registered state.
  always_comb begin
    ack    = ack_r;
    owner  = owner_r;
    starve = starve_r;
  end

  // Wait counters: count consecutive cycles a channel requests without the
  // grant; saturating at L+1 keeps the starvation indication from wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        wcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_r[i] && !ack_r[i]) begin
          if (wcnt[i] != WAIT_MAX) begin
            wcnt[i] <= wcnt[i] + 1'b1;
          end
        end else begin
          wcnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    wait_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (wcnt[i] == WAIT_MAX) begin
        wait_hit = 1'b1;
      end
    end
  end

  // Starvation flag is sticky until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_r <= 1'b0;
    end else begin
      starve_r <= starve_r | wait_hit;
    end
  end

endmodule

// File: doc/rrobin_n.md
# rrobin_n

Parametrised N-channel round-robin arbiter, successor to the two-channel arbiter. It latches raw requests, issues a registered one-hot grant with a rotating priority pointer and a configurable hold limit, and includes a per-channel wait monitor that flags starvation. It sits between request sources and a shared resource, and serves as the property target for the fairness checks.

## Interface

- `N`, default 4: number of channels, legal range 2..16.
- `HOLD`, default 1: maximum consecutive cycles one channel keeps the grant while another channel requests, legal range 1..15. `HOLD=1` reproduces the two-channel toggle behaviour.

- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `ir`  in  N: raw requests, sampled every posedge.
- `ack`  out  N: registered grant, one-hot or zero.
- `owner`  out  $clog2(N): index of the granted channel; meaningful only when `ack` is nonzero.
- `starve`  out  1: sticky flag; set when any channel's wait exceeds the bound.

## Operation

- Reset values: `req`=0, `ack`=0, `owner`=0, `ptr`=0, `hold_cnt`=0, all `wcnt`=0, `starve`=0.
- Latch: `req` <= `ir` every cycle.
- Grant update each posedge uses the current `req`, `ack`, `ptr` and `hold_cnt`:
  - `req`==0: `ack`=0 and `hold_cnt`=0; `ptr` is unchanged.
  - Owner `c` still requests, and either no other channel requests or `hold_cnt` < `HOLD`: keep the grant; `hold_cnt` increments, saturating at `HOLD`.
  - Otherwise: the winner is the first requesting channel scanning `ptr`, `ptr`+1, … mod N. Then `ack`=onehot(winner), `owner`=winner, `ptr`=(winner+1) mod N, `hold_cnt`=1.
  - If the only requester is the current owner, it keeps the grant indefinitely.
  - If the owner drops its request, its `ack` clears on the next update, and a new winner (if any) is granted on that same edge.
- Wait monitor, per channel i:
  - `wcnt[i]` increments when `req[i]` && !`ack[i]`; it clears otherwise.
  - It saturates at L+1, where L = (N-1)*HOLD + 1.
  - `starve` sets when any `wcnt` reaches L+1, and clears only on reset.
  - A correct arbiter never sets `starve`.

## Timing

- Latency from `ir` to `ack` is 2 cycles: one cycle to latch, one cycle to grant.
- With all channels requesting continuously and `HOLD`=h, each channel holds the grant for exactly h cycles, in the order ptr, ptr+1, ….
- Pointer wrap-around: `ptr` goes from N-1 to 0.
- Simultaneous first requests after idle: the channel at `ptr` wins. After reset this is channel 0.
- Reset asserted mid-grant: all state clears asynchronously. `ack`=0 holds until 2 cycles after deassertion, given requests are present.
- Counter widths:
  - `hold_cnt`: $clog2(HOLD+1) bits.
  - `wcnt`: $clog2(L+2) bits.
  - `ptr`: $clog2(N) bits.
  - All arithmetic is unsigned, mod N for `ptr`.

## Structure

- Package `rrobin_pkg`:
  - Function `rr_limit(N, HOLD)` returning L.
  - Width helper functions.
- Sub-module `rr_pick`: combinational. Inputs are `req` and `ptr`; outputs are `winner` index and `any`. It is implemented as a doubled-vector priority scan.
- Top level: latch register, grant/hold FSM, and N wait counters plus the `starve` register.

## Test plan

- N=4, HOLD=1, `ir`=4'b0011 held: from cycle 2 after reset, `ack` alternates 0001, 0010, 0001, …; `owner` alternates 0,1; `starve`=0.
- N=4, HOLD=2, `ir`=4'b1111 held: `ack` sequence 0001 ×2, 0010 ×2, 0100 ×2, 1000 ×2, then repeats. No channel's `wcnt` exceeds 7.
- N=4, HOLD=1, `ir`=4'b0100 only: `ack`=0100 held indefinitely, `owner`=2. After dropping `ir`, `ack`=0 two cycles later.
- N=4: grant channel 3, then `ir`=4'b1001 simultaneously. The pointer wraps, so channel 0 wins next and `ack`=0001.
- N=4: assert `reset` asynchronously while `ack`=0010 with `ir`=1111. `ack`=0 and `starve`=0 immediately. After release, the first grant goes to channel 0.
- Fault injection, N=3, HOLD=1: force `ack` stuck at 001 with `ir`=111. `starve` rises when channel 1's `wcnt` reaches 4 and stays high.
